// File: rtl/door_ctrl.sv
// Elevator car door controller: four-state open/close FSM with a travel-position
// counter, dwell-timer handshake and obstruction reversal.
module door_ctrl #(
    parameter logic [27:0] TRAVEL_CYC = 28'd50_000_000
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       at_floor,
    input  logic       open_req,
    input  logic       close_req,
    input  logic       obstruct,
    input  logic       delay_3s_done,
    output logic       delay_en,
    output logic       motor_open,
    output logic       motor_close,
    output logic       door_closed,
    output logic [1:0] door_state
);

    typedef enum logic [1:0] {
        StClosed  = 2'b00,
        StOpening = 2'b01,
        StOpen    = 2'b10,
        StClosing = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_state_d;
    logic [27:0] r_pos;
    logic [27:0] w_pos_d;
    logic        w_reopen;

    // Either a blocked edge or a fresh call keeps or drives the door open.
    assign w_reopen = obstruct | open_req;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StClosed;
            r_pos   <= 28'd0;
        end else begin
            r_state <= w_state_d;
            r_pos   <= w_pos_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_pos_d   = r_pos;
        case (r_state)
            StClosed: begin
                w_pos_d = 28'd0;
                if (at_floor && open_req) begin
                    w_state_d = StOpening;
                end
            end
            StOpening: begin
                // Saturating compare keeps pos within 0..TRAVEL_CYC.
                if (r_pos >= TRAVEL_CYC - 28'd1) begin
                    w_state_d = StOpen;
                    w_pos_d   = TRAVEL_CYC;
                end else begin
                    w_pos_d = r_pos + 28'd1;
                end
            end
            StOpen: begin
                if (!w_reopen && (delay_3s_done || close_req)) begin
                    w_state_d = StClosing;
                end
            end
            StClosing: begin
                if (w_reopen) begin
                    w_state_d = StOpening;
                end else if (r_pos <= 28'd1) begin
                    w_state_d = StClosed;
                    w_pos_d   = 28'd0;
                end else begin
                    w_pos_d = r_pos - 28'd1;
                end
            end
            default: begin
                w_state_d = StClosed;
                w_pos_d   = 28'd0;
            end
        endcase
    end

    assign motor_open  = (r_state == StOpening);
    assign motor_close = (r_state == StClosing);
    assign door_closed = (r_state == StClosed);
    assign door_state  = r_state;
    assign delay_en    = (r_state == StOpen) & ~obstruct & ~open_req;

endmodule

// File: tb/tb_door_ctrl.sv
// Directed bench for door_ctrl with TRAVEL_CYC=4 and a behavioural dwell timer
// that raises done after 10 enabled cycles.
module tb_door_ctrl;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic       at_floor, open_req, close_req, obstruct;
    logic       delay_3s_done;
    logic       delay_en, motor_open, motor_close, door_closed;
    logic [1:0] door_state;
    logic [3:0] tmr_cnt;
    int         n_cmp = 0;
    int         n_err = 0;

    door_ctrl #(.TRAVEL_CYC(28'd4)) dut (
        .clk_50M      (clk_50M),
        .rst_n        (rst_n),
        .at_floor     (at_floor),
        .open_req     (open_req),
        .close_req    (close_req),
        .obstruct     (obstruct),
        .delay_3s_done(delay_3s_done),
        .delay_en     (delay_en),
        .motor_open   (motor_open),
        .motor_close  (motor_close),
        .door_closed  (door_closed),
        .door_state   (door_state)
    );

    always #10 clk_50M = ~clk_50M;

    always @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            tmr_cnt       <= 4'd0;
            delay_3s_done <= 1'b0;
        end else if (!delay_en) begin
            tmr_cnt       <= 4'd0;
            delay_3s_done <= 1'b0;
        end else begin
            if (tmr_cnt != 4'd10) tmr_cnt <= tmr_cnt + 4'd1;
            delay_3s_done <= (tmr_cnt >= 4'd9);
        end
    end

    task automatic open_door;
        at_floor = 1'b1;
        open_req = 1'b1;
        @(negedge clk_50M);
        open_req = 1'b0;
        repeat (4) @(negedge clk_50M);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        at_floor = 1'b0; open_req = 1'b0; close_req = 1'b0; obstruct = 1'b0;
        repeat (2) @(negedge clk_50M);
        n_cmp++;
        if ({door_state, door_closed, motor_open, motor_close, delay_en} !== 6'b00_1000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 001000",
                     {door_state, door_closed, motor_open, motor_close, delay_en});
        end
        n_cmp++;
        if (dut.r_pos !== 28'd0) begin
            n_err++;
            $display("FAIL reset_pos: got %0d want 0", dut.r_pos);
        end
        rst_n = 1'b1;
        at_floor = 1'b1;
        repeat (3) @(negedge clk_50M);
        n_cmp++;
        if (door_state !== 2'b00) begin
            n_err++;
            $display("FAIL post_reset_idle: got %b want 00", door_state);
        end
    endtask

    task automatic test_open_close;
        int n;
        at_floor = 1'b1;
        open_req = 1'b1;
        @(negedge clk_50M);
        open_req = 1'b0;
        at_floor = 1'b0;  // leaving the floor mid-cycle must not matter
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (door_state !== 2'b01 || motor_open !== 1'b1 || dut.r_pos !== 28'(i)) begin
                n_err++;
                $display("FAIL opening_%0d: state %b motor_open %b pos %0d want 01 1 %0d",
                         i, door_state, motor_open, dut.r_pos, i);
            end
            @(negedge clk_50M);
        end
        n_cmp++;
        if (door_state !== 2'b10 || delay_en !== 1'b1 || dut.r_pos !== 28'd4) begin
            n_err++;
            $display("FAIL open_reached: state %b delay_en %b pos %0d want 10 1 4",
                     door_state, delay_en, dut.r_pos);
        end
        n = 0;
        while (door_state == 2'b10 && n < 50) begin
            @(negedge clk_50M);
            n++;
        end
        n_cmp++;
        if (n != 11) begin
            n_err++;
            $display("FAIL dwell_len: got %0d cycles want 11", n);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (door_state !== 2'b11 || motor_close !== 1'b1 || dut.r_pos !== 28'(4 - i)) begin
                n_err++;
                $display("FAIL closing_%0d: state %b motor_close %b pos %0d want 11 1 %0d",
                         i, door_state, motor_close, dut.r_pos, 4 - i);
            end
            @(negedge clk_50M);
        end
        n_cmp++;
        if (door_state !== 2'b00 || door_closed !== 1'b1 || dut.r_pos !== 28'd0) begin
            n_err++;
            $display("FAIL closed_again: state %b door_closed %b pos %0d want 00 1 0",
                     door_state, door_closed, dut.r_pos);
        end
    endtask

    task automatic test_no_floor;
        at_floor = 1'b0;
        open_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50M);
            n_cmp++;
            if (door_state !== 2'b00 || motor_open !== 1'b0 || motor_close !== 1'b0) begin
                n_err++;
                $display("FAIL no_floor_%0d: state %b motors %b%b want 00 00",
                         i, door_state, motor_open, motor_close);
            end
        end
        open_req = 1'b0;
    endtask

    task automatic test_reverse;
        open_door();
        close_req = 1'b1;
        @(negedge clk_50M);
        close_req = 1'b0;
        n_cmp++;
        if (door_state !== 2'b11 || dut.r_pos !== 28'd4) begin
            n_err++;
            $display("FAIL close_req_early: state %b pos %0d want 11 4", door_state, dut.r_pos);
        end
        repeat (2) @(negedge clk_50M);
        obstruct = 1'b1;
        @(negedge clk_50M);
        obstruct = 1'b0;
        n_cmp++;
        if (door_state !== 2'b01 || dut.r_pos !== 28'd2) begin
            n_err++;
            $display("FAIL reverse: state %b pos %0d want 01 2", door_state, dut.r_pos);
        end
        repeat (2) @(negedge clk_50M);
        n_cmp++;
        if (door_state !== 2'b10 || dut.r_pos !== 28'd4) begin
            n_err++;
            $display("FAIL reopen: state %b pos %0d want 10 4", door_state, dut.r_pos);
        end
    endtask

    task automatic test_obstruct_hold;
        obstruct  = 1'b1;
        close_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1;
            n_cmp++;
            if (door_state !== 2'b10 || delay_en !== 1'b0) begin
                n_err++;
                $display("FAIL obstruct_hold_%0d: state %b delay_en %b want 10 0",
                         i, door_state, delay_en);
            end
            @(negedge clk_50M);
        end
        obstruct  = 1'b0;
        close_req = 1'b0;
    endtask

    task automatic test_open_vs_done;
        int n;
        n = 0;
        while (delay_3s_done !== 1'b1 && n < 50) begin
            @(negedge clk_50M);
            n++;
        end
        n_cmp++;
        if (delay_3s_done !== 1'b1 || door_state !== 2'b10) begin
            n_err++;
            $display("FAIL wait_done: done %b state %b want 1 10", delay_3s_done, door_state);
        end
        open_req = 1'b1;
        #1;
        n_cmp++;
        if (delay_en !== 1'b0) begin
            n_err++;
            $display("FAIL open_vs_done_en: got %b want 0", delay_en);
        end
        @(negedge clk_50M);
        open_req = 1'b0;
        n_cmp++;
        if (door_state !== 2'b10 || delay_3s_done !== 1'b0) begin
            n_err++;
            $display("FAIL open_vs_done_hold: state %b done %b want 10 0",
                     door_state, delay_3s_done);
        end
        n = 0;
        while (door_state == 2'b10 && n < 50) begin
            @(negedge clk_50M);
            n++;
        end
        n_cmp++;
        if (n != 11) begin
            n_err++;
            $display("FAIL redwell_len: got %0d cycles want 11", n);
        end
        repeat (4) @(negedge clk_50M);
        n_cmp++;
        if (door_closed !== 1'b1 || dut.r_pos !== 28'd0) begin
            n_err++;
            $display("FAIL redwell_closed: door_closed %b pos %0d want 1 0",
                     door_closed, dut.r_pos);
        end
    endtask

    task automatic test_reset_mid;
        at_floor = 1'b1;
        open_req = 1'b1;
        @(negedge clk_50M);
        open_req = 1'b0;
        repeat (2) @(negedge clk_50M);
        n_cmp++;
        if (door_state !== 2'b01 || dut.r_pos !== 28'd2) begin
            n_err++;
            $display("FAIL pre_reset: state %b pos %0d want 01 2", door_state, dut.r_pos);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({door_state, door_closed, motor_open, motor_close} !== 5'b00_100 ||
            dut.r_pos !== 28'd0) begin
            n_err++;
            $display("FAIL async_reset: got %b pos %0d want 00100 0",
                     {door_state, door_closed, motor_open, motor_close}, dut.r_pos);
        end
        @(negedge clk_50M);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_50M);
        n_cmp++;
        if (door_state !== 2'b00) begin
            n_err++;
            $display("FAIL reset_needs_req: got %b want 00", door_state);
        end
    endtask

    initial begin
        test_reset();
        test_open_close();
        test_no_floor();
        test_reverse();
        test_obstruct_hold();
        test_open_vs_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
